// File: rtl/kugelblitz_tx_arbiter_if.sv
// AXI-stream bundle used for both source ports and the output port of the
// QSFP TX arbiter.
interface kugelblitz_tx_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/kugelblitz_tx_arbiter.sv
// Frame-granular 2:1 AXI-stream arbiter for one QSFP TX datapath.
// Port 0 = host TX, port 1 = offload frames. A grant is held from the first
// accepted beat to the accepted tlast beat, so frames never interleave.
// One registered output stage; per-port frame counters on input tlast.
module kugelblitz_tx_arbiter #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int USER_WIDTH    = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  kugelblitz_tx_arbiter_if.slave  s0,
  kugelblitz_tx_arbiter_if.slave  s1,
  kugelblitz_tx_arbiter_if.master m,
  output logic [1:0]              grant,
  output logic [31:0]             frame_count_0,
  output logic [31:0]             frame_count_1
);

  if (DATA_WIDTH != 512) begin : g_bad_data_width
    $error("kugelblitz_tx_arbiter: DATA_WIDTH must be 512");
  end
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep_width
    $error("kugelblitz_tx_arbiter: KEEP_WIDTH*8 must equal DATA_WIDTH");
  end
  if (USER_WIDTH < 1) begin : g_bad_user_width
    $error("kugelblitz_tx_arbiter: USER_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

  state_t state;
  logic   last_grant;   // port that completed the most recent frame
  logic   out_ok;       // output register can take a beat this cycle
  logic   acc0, acc1;
  logic   pick;         // arbitration winner in IDLE: 1 = port 1

  assign out_ok    = m.tready | ~m.tvalid;
  assign s0.tready = (state == PASS0) & out_ok;
  assign s1.tready = (state == PASS1) & out_ok;
  assign acc0      = s0.tvalid & s0.tready;
  assign acc1      = s1.tvalid & s1.tready;

  // Winner selection: offload-first in fixed-priority mode, otherwise the
  // port that did not finish the last frame wins a tie.
  always_comb begin
    pick = 1'b0;
    if (PRIORITY_MODE != 0)
      pick = s1.tvalid;
    else if (s0.tvalid && s1.tvalid)
      pick = ~last_grant;
    else
      pick = s1.tvalid;
  end

  // Grant FSM with registered grant, last winner and frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= 2'b00;
      last_grant    <= 1'b1;
      frame_count_0 <= '0;
      frame_count_1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && (s0.tvalid || s1.tvalid)) begin
            state <= pick ? PASS1 : PASS0;
            grant <= pick ? 2'b10 : 2'b01;
          end
        end
        PASS0: begin
          if (acc0 && s0.tlast) begin
            state         <= IDLE;
            grant         <= 2'b00;
            last_grant    <= 1'b0;
            frame_count_0 <= frame_count_0 + 32'd1;
          end
        end
        PASS1: begin
          if (acc1 && s1.tlast) begin
            state         <= IDLE;
            grant         <= 2'b00;
            last_grant    <= 1'b1;
            frame_count_1 <= frame_count_1 + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Output valid: set on any accepted beat, cleared once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      m.tvalid <= 1'b0;
    else if (acc0 || acc1)
      m.tvalid <= 1'b1;
    else if (m.tready)
      m.tvalid <= 1'b0;
  end

  // Output payload: loads only on acceptance, so it holds during stalls.
  always_ff @(posedge clk) begin
    if (acc0) begin
      m.tdata <= s0.tdata;
      m.tkeep <= s0.tkeep;
      m.tlast <= s0.tlast;
      m.tuser <= s0.tuser;
    end else if (acc1) begin
      m.tdata <= s1.tdata;
      m.tkeep <= s1.tkeep;
      m.tlast <= s1.tlast;
      m.tuser <= s1.tuser;
    end
  end

endmodule

// File: tb/tb_kugelblitz_tx_arbiter.sv
// Bench for kugelblitz_tx_arbiter: table rows of directed frame scenarios,
// hand sequences for enable/wrap/reset, a fixed-priority instance, and a
// randomized run, all against a frame-level reference model.
module tb_kugelblitz_tx_arbiter;
  localparam int DW = 512;
  localparam int KW = 64;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [0:0]    user;
  } beat_t;

  typedef struct {
    int         n0, n1, len;
    logic [3:0] rdy;
    int         nfr;
    logic [7:0] ord;   // bit i = source port of the i-th output frame
    int         c0, c1;
    int         bub;   // idle output cycles between frames, -1 = don't care
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  grant, grant_p;
  logic [31:0] fc0, fc1, fc0p, fc1p;

  kugelblitz_tx_arbiter_if #(.DATA_WIDTH(DW)) s0(), s1(), m(), s0p(), s1p(), mp();

  kugelblitz_tx_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s0(s0), .s1(s1), .m(m),
    .grant(grant), .frame_count_0(fc0), .frame_count_1(fc1));

  kugelblitz_tx_arbiter #(.PRIORITY_MODE(1)) dut_p (
    .clk(clk), .rst(rst), .enable(enable), .s0(s0p), .s1(s1p), .m(mp),
    .grant(grant_p), .frame_count_0(fc0p), .frame_count_1(fc1p));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // sources and reference model
  beat_t       q0[$], q1[$];
  logic        pv0, pv1, f0, f1, pen, pmr;
  int          mst;            // 0 idle, 1 serving port 0, 2 serving port 1
  logic        mlast, mvld;
  beat_t       mb;
  logic [31:0] mc0, mc1;
  int          gen0, gen1, gap_pct, pat_i;
  logic        rnd_rdy;
  logic [3:0]  rdy_pat;
  int          ord[$];
  logic        in_out, seen;
  int          bub, nbeat, tot;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_frame(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < DW/32; k++) b.data[k*32 +: 32] = $urandom();
      b.data[7:0] = 8'(port);
      b.last = (i == len - 1);
      b.keep = b.last ? 64'h0000_0000_FFFF_FFFF : '1;
      b.user = 1'($urandom_range(1));
      if (port == 0) q0.push_back(b); else q1.push_back(b);
    end
    if (port == 0) gen0++; else gen1++;
  endtask

  // Frame-level behaviour for one clock edge, from the inputs latched before it.
  task automatic model_edge();
    beat_t b;
    logic  win;
    b = q0.size() > 0 ? q0[0] : mb;
    if (f0) begin b = q0.pop_front(); pv0 = 1'b0; end
    else if (f1) begin b = q1.pop_front(); pv1 = 1'b0; end
    if (f0 || f1) begin mvld = 1'b1; mb = b; end
    else if (pmr) mvld = 1'b0;
    case (mst)
      0: if (pen && (pv0 || pv1)) begin
           win = (pv0 && pv1) ? !mlast : pv1;
           mst = win ? 2 : 1;
         end
      1: if (f0 && b.last) begin mst = 0; mlast = 1'b0; mc0++; end
      default: if (f1 && b.last) begin mst = 0; mlast = 1'b1; mc1++; end
    endcase
  endtask

  // One clock: drive inputs at the negedge, let the posedge pass, then compare.
  task automatic cycle();
    logic [1:0] eg;
    if (!pv0 && q0.size() > 0 && $urandom_range(99) >= gap_pct) pv0 = 1'b1;
    if (!pv1 && q1.size() > 0 && $urandom_range(99) >= gap_pct) pv1 = 1'b1;
    s0.tvalid = pv0;
    if (pv0) begin s0.tdata = q0[0].data; s0.tkeep = q0[0].keep; s0.tlast = q0[0].last; s0.tuser = q0[0].user; end
    s1.tvalid = pv1;
    if (pv1) begin s1.tdata = q1[0].data; s1.tkeep = q1[0].keep; s1.tlast = q1[0].last; s1.tuser = q1[0].user; end
    m.tready = rnd_rdy ? ($urandom_range(2) != 0) : rdy_pat[pat_i % 4];
    pat_i++;
    pen = enable;
    pmr = m.tready;
    f0  = pv0 && mst == 1 && (m.tready || !mvld);
    f1  = pv1 && mst == 2 && (m.tready || !mvld);
    // output-side frame order and inter-frame gaps
    if (m.tvalid && m.tready) begin
      if (!in_out) ord.push_back(int'(m.tdata[7:0]));
      in_out = !m.tlast;
      nbeat++;
      seen = 1'b1;
    end else if (seen && !m.tvalid && nbeat < tot) bub++;
    @(negedge clk);
    model_edge();
    eg = mst == 1 ? 2'b01 : mst == 2 ? 2'b10 : 2'b00;
    chk("grant", 64'(grant), 64'(eg));
    chk("s0_tready", 64'(s0.tready), 64'(mst == 1 && (m.tready || !mvld)));
    chk("s1_tready", 64'(s1.tready), 64'(mst == 2 && (m.tready || !mvld)));
    chk("m_tvalid", 64'(m.tvalid), 64'(mvld));
    if (mvld) begin
      chkd("m_tdata", m.tdata, mb.data);
      chk("m_tkeep", m.tkeep, mb.keep);
      chk("m_tlast", 64'(m.tlast), 64'(mb.last));
      chk("m_tuser", 64'(m.tuser), 64'(mb.user));
    end
    chk("frame_count_0", 64'(fc0), 64'(mc0));
    chk("frame_count_1", 64'(fc1), 64'(mc1));
  endtask

  function automatic bit drained();
    return q0.size() == 0 && q1.size() == 0 && !pv0 && !pv1 && mst == 0 && !mvld;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!drained() && n < budget) begin cycle(); n++; end
    chk("drain_timeout", 64'(drained()), 64'd1);
  endtask

  // Called at a negedge; asserts reset between edges and checks it acts at once.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_m_tvalid", 64'(m.tvalid), '0);
    chk("rst_grant", 64'(grant), '0);
    chk("rst_s0_tready", 64'(s0.tready), '0);
    chk("rst_s1_tready", 64'(s1.tready), '0);
    chk("rst_count0", 64'(fc0), '0);
    chk("rst_count1", 64'(fc1), '0);
    q0.delete(); q1.delete(); ord.delete();
    pv0 = 0; pv1 = 0; f0 = 0; f1 = 0; mst = 0; mlast = 1; mvld = 0; mc0 = 0; mc1 = 0;
    gen0 = 0; gen1 = 0; gap_pct = 0; rnd_rdy = 0; rdy_pat = 4'b1111; pat_i = 0;
    in_out = 0; seen = 0; bub = 0; nbeat = 0; tot = 1 << 30;
    s0.tvalid = 0; s1.tvalid = 0; s0p.tvalid = 0; s1p.tvalid = 0;
    m.tready = 1; mp.tready = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    apply_reset();
    enable  = 1'b1;
    rdy_pat = v.rdy;
    tot     = (v.n0 + v.n1) * v.len;
    for (int i = 0; i < v.n0; i++) add_frame(0, v.len);
    for (int i = 0; i < v.n1; i++) add_frame(1, v.len);
    drain(400);
    chk("row_count0", 64'(fc0), 64'(v.c0));
    chk("row_count1", 64'(fc1), 64'(v.c1));
    chk("row_nframes", 64'(ord.size()), 64'(v.nfr));
    for (int i = 0; i < v.nfr && i < ord.size(); i++)
      chk("row_order", 64'(ord[i]), 64'(v.ord[i]));
    if (v.bub >= 0) chk("row_bubbles", 64'(bub), 64'(v.bub));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[5];
    int   n, p0w;
    tbl[0] = '{1, 0, 3, 4'b1111, 1, 8'h00, 1, 0, 0};   // single 3-beat frame
    tbl[1] = '{2, 2, 2, 4'b1111, 4, 8'h0A, 2, 2, 3};   // round-robin 0,1,0,1
    tbl[2] = '{1, 0, 4, 4'b1001, 1, 8'h00, 1, 0, -1};  // backpressure 1,0,0,1
    tbl[3] = '{0, 3, 1, 4'b1111, 3, 8'h07, 0, 3, 2};   // 1-beat frames on port 1
    tbl[4] = '{3, 1, 2, 4'b1101, 4, 8'h02, 3, 1, -1};  // 0,1,0,0 with stalls

    s0.tvalid = 0; s1.tvalid = 0; m.tready = 1;
    s0p.tvalid = 0; s1p.tvalid = 0; mp.tready = 1;
    s0p.tdata = '0; s0p.tkeep = '1; s0p.tlast = 1; s0p.tuser = '0;
    s1p.tdata = '0; s1p.tkeep = '1; s1p.tlast = 1; s1p.tuser = '0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_row(tbl[i]);

    // enable dropped mid-frame: frame finishes, no new grant until re-enabled
    apply_reset();
    enable = 1'b1;
    add_frame(0, 4);
    n = 0;
    while (mst != 1 && n < 10) begin cycle(); n++; end
    cycle();
    enable = 1'b0;
    add_frame(1, 2);
    repeat (12) cycle();
    chk("en_count0", 64'(fc0), 64'd1);
    chk("en_count1", 64'(fc1), 64'd0);
    chk("en_idle_grant", 64'(grant), 64'd0);
    enable = 1'b1;
    drain(100);
    chk("en_resume_count1", 64'(fc1), 64'd1);

    // counter wrap on port 1
    apply_reset();
    enable = 1'b1;
    force dut.frame_count_1 = 32'hFFFF_FFFF;
    mc1 = 32'hFFFF_FFFF;
    cycle();
    release dut.frame_count_1;
    add_frame(1, 2);
    drain(50);
    chk("wrap_count1", 64'(fc1), 64'd0);

    // asynchronous reset during beat 2, then first tie goes to port 0
    apply_reset();
    enable = 1'b1;
    add_frame(0, 4);
    n = 0;
    while (q0.size() > 2 && n < 20) begin cycle(); n++; end
    chk("pre_reset_grant", 64'(grant), 64'd1);
    apply_reset();
    enable = 1'b1;
    add_frame(0, 1);
    add_frame(1, 1);
    cycle();
    chk("tie_after_reset", 64'(grant), 64'd1);
    drain(50);
    chk("after_reset_count0", 64'(fc0), 64'd1);
    chk("after_reset_count1", 64'(fc1), 64'd1);

    // fixed priority instance: port 1 owns the link while it keeps requesting
    apply_reset();
    enable = 1'b1;
    s0p.tvalid = 1'b1;
    s1p.tvalid = 1'b1;
    p0w = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (grant_p == 2'b01 || s0p.tready) p0w++;
    end
    chk("prio_port0_served", 64'(p0w), 64'd0);
    chk("prio_count1", 64'(fc1p), 64'd8);
    chk("prio_count0", 64'(fc0p), 64'd0);
    s1p.tvalid = 1'b0;
    @(negedge clk);
    chk("prio_port0_grant", 64'(grant_p), 64'd1);
    @(negedge clk);
    chk("prio_port0_count", 64'(fc0p), 64'd1);
    s0p.tvalid = 1'b0;

    // randomized traffic, gaps, backpressure and enable toggling
    apply_reset();
    enable  = 1'b1;
    gap_pct = 30;
    rnd_rdy = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() < 8 && $urandom_range(3) == 0) add_frame(0, 1 + int'($urandom_range(4)));
      if (q1.size() < 8 && $urandom_range(3) == 0) add_frame(1, 1 + int'($urandom_range(4)));
      enable = ($urandom_range(15) != 0);
      cycle();
    end
    enable  = 1'b1;
    gap_pct = 0;
    drain(800);
    chk("rand_count0", 64'(fc0), 64'(gen0));
    chk("rand_count1", 64'(fc1), 64'(gen1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kugelblitz_tx_arbiter.md
Name: kugelblitz_tx_arbiter

Overview:
- Frame-granular 2:1 AXI-stream arbiter that shares one 512-bit QSFP TX datapath between two sources.
- Port 0 carries host TX traffic from the interface TX path. Port 1 carries offload-generated frames.
- Sits immediately upstream of the per-QSFP TX offload/pad stage. One instance per QSFP TX clock domain.
- Never interleaves beats of different frames. Provides one registered output stage and per-port frame counters.

Parameters:
- DATA_WIDTH, 512, AXI-stream data width in bits; only 512 is supported (elaboration $error otherwise).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width; KEEP_WIDTH*8 must equal DATA_WIDTH (elaboration $error otherwise).
- USER_WIDTH, 1, tuser width.
- PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 1 (offload) wins.

Ports:
- clk  input  1  QSFP TX clock.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  when low, no new grant is issued; a frame in progress completes.
- s0_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  host source stream.
- s1_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  offload source stream.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  arbitrated output stream.
- grant  output  2  one-hot current grant; 2'b00 when idle.
- frame_count_0  output  32  frames accepted from port 0.
- frame_count_1  output  32  frames accepted from port 1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - m_axis_tvalid=0, s0/s1_axis_tready=0, grant=0, state=IDLE.
  - last_grant=1, so port 0 wins the first round-robin tie.
  - frame_count_0 and frame_count_1 = 0.
  - m_axis_tdata/tkeep/tlast/tuser are don't-care while m_axis_tvalid=0.
- State machine: IDLE, PASS0, PASS1.
  - IDLE: all s_tready=0.
  - IDLE → grant: if enable=1 and any s_tvalid=1, select a port and move to PASS0 or PASS1 on the next edge. This costs one idle cycle of arbitration latency.
  - Round-robin (PRIORITY_MODE=0): the port other than last_grant wins when both request. A sole requester always wins.
  - Fixed priority (PRIORITY_MODE=1): port 1 wins whenever s1_axis_tvalid=1.
  - PASSx: grant[x]=1. The non-granted s_tready is held 0.
  - PASSx → IDLE: on an accepted beat of port x with tlast=1. At the same edge, last_grant<=x and frame_count_x increments.
- Output register:
  - Single pipeline register. s_x_tready = m_axis_tready | ~m_axis_tvalid (granted port only).
  - An accepted input beat appears on m_axis_* the next cycle. Latency is 1 cycle.
  - Throughput is one beat per cycle within a frame. There is exactly one bubble cycle between consecutive frames.
  - m_axis_* holds stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-stream rule).
- Data passes unmodified: tdata, tkeep, tlast and tuser are copied bit-exact. No padding or masking is done here.
- enable deasserted while in PASSx: the current frame completes normally, then the block stays in IDLE until enable=1.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0. They count on input-side tlast acceptance, not on output drain.
- Source dropping tvalid mid-frame: the grant is held. The arbiter waits indefinitely for the rest of the frame; there is no timeout.
- Reset mid-frame: the frame is truncated with no tlast emitted. Upstream must also be reset.

Test Plan:
1. Single-port frame: s0 sends a 3-beat frame, tkeep last=0x0000_0000_FFFF_FFFF, m_tready=1.
   - grant=01 one cycle after s0_tvalid rises.
   - Output beats arrive 1 cycle after acceptance, bit-exact.
   - frame_count_0=1.
2. Round-robin contention: both ports continuously offer 2-beat frames, PRIORITY_MODE=0.
   - Output frame order is 0,1,0,1.
   - Exactly one m_tvalid=0 cycle between frames; no beat interleaving.
3. Fixed priority: PRIORITY_MODE=1, both ports request.
   - Port 1 frames always win while s1_tvalid=1.
   - Port 0 is served only when s1_tvalid=0 in IDLE.
4. Backpressure: m_tready toggles 1,0,0,1 during a 4-beat frame.
   - m_axis_* stays stable during stalls; no beat lost or duplicated.
   - Total output is 4 beats with tlast on beat 4.
5. enable and counter wrap:
   - Drop enable mid-frame: that frame completes, then no new grant while s1_tvalid=1.
   - Preset frame_count_1 to 0xFFFFFFFF via stimulus of 2^32 frames (or force): the next port-1 frame gives frame_count_1=0.
6. Async reset mid-frame: assert rst during beat 2 of a frame.
   - m_tvalid=0, grant=00 and counters=0 immediately, without a clock edge.
   - After release, port 0 wins the first tie.
